// File: rtl/ultra_echo_timer_pkg.sv
// rtl/ultra_echo_timer_pkg.sv - shared state encoding, count width and sensor timing defaults
package ultra_echo_timer_pkg;

  localparam int COUNT_W = 8;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  localparam int DEF_TRIG_CYCLES = 10;
  localparam int DEF_TICK_DIV    = 58;
  localparam int DEF_WAIT_MAX    = 30000;
  localparam int DEF_ECHO_MAX    = 60000;
  localparam int DEF_GAP_CYCLES  = 60000;
  localparam int DEF_CALC_HOLD   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_REPORT,
    ST_GAP
  } state_t;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ultra_echo_timer_if.sv
// rtl/ultra_echo_timer_if.sv - sensor pins and divider hookup of the echo timer
interface ultra_echo_timer_if;
  import ultra_echo_timer_pkg::*;

  logic               start;
  logic               echo;
  logic               trigger;
  logic [COUNT_W-1:0] count;
  logic               calculate;
  logic               busy;
  logic               timeout;

  modport master (output start, echo, input trigger, count, calculate, busy, timeout);
  modport slave  (input start, echo, output trigger, count, calculate, busy, timeout);

endinterface

// File: rtl/ultra_sync2.sv
// rtl/ultra_sync2.sv - generic two-flop synchronizer
module ultra_sync2 #(
  parameter int W = 1
) (
  input  logic         CLKOUTD,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge CLKOUTD) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultra_echo_timer.sv
// rtl/ultra_echo_timer.sv - fires the sensor trigger, times the echo in prescaled ticks
// and hands a saturating 8-bit round-trip count plus calculate strobe to the divider.
module ultra_echo_timer
  import ultra_echo_timer_pkg::*;
#(
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int WAIT_MAX    = DEF_WAIT_MAX,
  parameter int ECHO_MAX    = DEF_ECHO_MAX,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CALC_HOLD   = DEF_CALC_HOLD
) (
  input logic               CLKOUTD,
  input logic               reset,
  ultra_echo_timer_if.slave bus
);

  localparam int CYC_MAX = imax(imax(imax(TRIG_CYCLES, WAIT_MAX), imax(ECHO_MAX, GAP_CYCLES)),
                                CALC_HOLD);
  localparam int CW = $clog2(CYC_MAX + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] ECHO_LAST = CW'(ECHO_MAX - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CALC_LAST = CW'(CALC_HOLD - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);

  state_t             st, st_n;
  logic [CW-1:0]      cyc, cyc_n;
  logic [PW-1:0]      pre, pre_n;
  logic [COUNT_W-1:0] tick, tick_n, tick_adv;
  logic [COUNT_W-1:0] count_q, count_n;
  logic               tmo, tmo_n;
  logic               wrap;
  logic               echo_s;
  logic               trig_q, calc_q, busy_q;

  ultra_sync2 #(.W(1)) u_echo_sync (
    .CLKOUTD (CLKOUTD),
    .reset   (reset),
    .d       (bus.echo),
    .q       (echo_s)
  );

  always_ff @(posedge CLKOUTD) begin
    if (reset) begin
      st      <= ST_IDLE;
      cyc     <= '0;
      pre     <= '0;
      tick    <= '0;
      count_q <= '0;
      tmo     <= 1'b0;
      trig_q  <= 1'b0;
      calc_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st      <= st_n;
      cyc     <= cyc_n;
      pre     <= pre_n;
      tick    <= tick_n;
      count_q <= count_n;
      tmo     <= tmo_n;
      trig_q  <= (st_n == ST_TRIG);
      calc_q  <= (st_n == ST_REPORT);
      busy_q  <= (st_n != ST_IDLE);
    end
  end

  // The cycle that ends MEASURE still counts as an echo sample, so the report
  // takes the advanced tick value: E synced high cycles give floor(E/TICK_DIV).
  always_comb begin
    st_n     = st;
    cyc_n    = cyc + 1'b1;
    pre_n    = pre;
    tick_n   = tick;
    count_n  = count_q;
    tmo_n    = tmo;
    wrap     = (pre == PRE_LAST);
    tick_adv = (wrap && tick != COUNT_MAX) ? tick + 1'b1 : tick;
    case (st)
      ST_IDLE: begin
        cyc_n = '0;
        if (bus.start) begin
          st_n  = ST_TRIG;
          tmo_n = 1'b0;
        end
      end
      ST_TRIG: begin
        if (cyc == TRIG_LAST) begin
          st_n  = ST_WAIT_RISE;
          cyc_n = '0;
        end
      end
      ST_WAIT_RISE: begin
        if (echo_s) begin
          st_n   = ST_MEASURE;
          cyc_n  = '0;
          pre_n  = '0;
          tick_n = '0;
        end else if (cyc == WAIT_LAST) begin
          st_n  = ST_GAP;
          cyc_n = '0;
          tmo_n = 1'b1;
        end
      end
      ST_MEASURE: begin
        pre_n  = wrap ? '0 : pre + 1'b1;
        tick_n = tick_adv;
        if (!echo_s || cyc == ECHO_LAST) begin
          st_n    = ST_REPORT;
          cyc_n   = '0;
          count_n = tick_adv;
          if (echo_s) tmo_n = 1'b1;
        end
      end
      ST_REPORT: begin
        if (cyc == CALC_LAST) begin
          st_n  = ST_GAP;
          cyc_n = '0;
        end
      end
      ST_GAP: begin
        if (cyc == GAP_LAST) begin
          st_n  = ST_IDLE;
          cyc_n = '0;
        end
      end
      default: begin
        st_n  = ST_IDLE;
        cyc_n = '0;
      end
    endcase
  end

  assign bus.trigger   = trig_q;
  assign bus.calculate = calc_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.timeout   = tmo;

endmodule
